// File: rtl/rom_loader_ctrl.sv
// ROM download controller: buffers HPS download bytes in a 4-entry FIFO and issues
// region-decoded writes to the ROM memories. Define ROM_LOADER_CHECKSUM_EN to add a byte checksum output.
module rom_loader_ctrl #(
  parameter logic [16:0] SND_BASE = 17'h0C000,
  parameter logic [16:0] GFX_BASE = 17'h0D000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [16:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [1:0]  mem_sel,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        overflow
`ifdef ROM_LOADER_CHECKSUM_EN
  , output logic [7:0] checksum
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state, state_next;

  logic [24:0] fifo [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        push, pop, ovf_set, enter_load;
  logic [16:0] head_addr;
  logic [1:0]  head_sel;
  logic [15:0] head_off;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    cpu_hold   = 1'b1;
    load_done  = 1'b0;
    case (state)
      IDLE:  if (ioctl_download) state_next = LOAD;
      LOAD:  if (!ioctl_download) state_next = DRAIN;
      DRAIN: if (count == 3'd0 && !mem_req) state_next = DONE;
      DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
        if (ioctl_download) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  assign enter_load = (state == IDLE || state == DONE) && state_next == LOAD;

  // A pop in the same cycle frees a slot, so a strobe into a full FIFO is still accepted.
  assign pop     = !mem_req && count != 3'd0;
  assign push    = ioctl_wr && state == LOAD && (count != 3'd4 || pop);
  assign ovf_set = ioctl_wr && state == LOAD && count == 3'd4 && !pop;

  always_ff @(posedge clk_sys) begin
    if (push) fifo[wr_ptr] <= {ioctl_addr, ioctl_dout};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

  // Offsets only need the low 16 bits, so subtract on the truncated values.
  assign head_addr = fifo[rd_ptr][24:8];
  always_comb begin
    head_sel = 2'd0;
    head_off = head_addr[15:0];
    if (head_addr >= GFX_BASE) begin
      head_sel = 2'd2;
      head_off = head_addr[15:0] - GFX_BASE[15:0];
    end else if (head_addr >= SND_BASE) begin
      head_sel = 2'd1;
      head_off = head_addr[15:0] - SND_BASE[15:0];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_req  <= 1'b0;
      mem_sel  <= '0;
      mem_addr <= '0;
      mem_data <= '0;
    end else if (pop) begin
      mem_req  <= 1'b1;
      mem_sel  <= head_sel;
      mem_addr <= head_off;
      mem_data <= fifo[rd_ptr][7:0];
    end else if (mem_req && mem_ack) begin
      mem_req <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)        overflow <= 1'b0;
    else if (enter_load) overflow <= 1'b0;
    else if (ovf_set)    overflow <= 1'b1;
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)        checksum <= '0;
    else if (enter_load) checksum <= '0;
    else if (mem_req && mem_ack && state != DONE) checksum <= checksum + mem_data;
  end
`endif

endmodule

// File: tb/tb_rom_loader_ctrl.sv
// Directed self-checking bench for rom_loader_ctrl (covers ROM_LOADER_CHECKSUM_EN when defined).
module tb_rom_loader_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_wr, mem_ack;
  logic [16:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        mem_req, cpu_hold, load_done, overflow;
  logic [1:0]  mem_sel;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  rom_loader_ctrl #(.SND_BASE(17'h0C000), .GFX_BASE(17'h0D000)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .overflow(overflow)
`ifdef ROM_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [16:0] addr, input logic [7:0] data);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [1:0] sel,
                              input logic [15:0] addr, input logic [7:0] data);
    for (int i = 0; i < 20 && !mem_req; i++) tick();
    check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    check({tag, "_sel"}, {30'd0, mem_sel}, {30'd0, sel});
    check({tag, "_addr"}, {16'd0, mem_addr}, {16'd0, addr});
    check({tag, "_data"}, {24'd0, mem_data}, {24'd0, data});
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check({tag, "_req_drop"}, {31'd0, mem_req}, 32'd0);
  endtask

  logic seen_req;

  initial begin
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; mem_ack = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    #3;
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_sel", {30'd0, mem_sel}, 32'd0);
    check("rst_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_data", {24'd0, mem_data}, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_done", {31'd0, load_done}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    #10 reset_n = 1'b1;
    tick();

    // basic three-region download
    ioctl_download = 1'b1;
    tick();
    check("load_hold", {31'd0, cpu_hold}, 32'd1);
    strobe(17'h00000, 8'hA5);
    strobe(17'h0C001, 8'h3C);
    strobe(17'h0D002, 8'h7E);
    ioctl_download = 1'b0;
    expect_write("w0", 2'd0, 16'h0000, 8'hA5);
    expect_write("w1", 2'd1, 16'h0001, 8'h3C);
    expect_write("w2", 2'd2, 16'h0002, 8'h7E);
    tick(); tick();
    check("done1_load_done", {31'd0, load_done}, 32'd1);
    check("done1_hold", {31'd0, cpu_hold}, 32'd0);

    // second download: overflow with ack held off
    ioctl_download = 1'b1;
    tick();
    check("reload_done", {31'd0, load_done}, 32'd0);
    check("reload_hold", {31'd0, cpu_hold}, 32'd1);
    for (int i = 0; i < 6; i++) strobe(17'h00010 + 17'(i), 8'h10 + 8'(i));
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_head_req", {31'd0, mem_req}, 32'd1);
    check("ovf_head_data", {24'd0, mem_data}, 32'h10);
    for (int i = 0; i < 5; i++)
      expect_write($sformatf("ovf_w%0d", i), 2'd0, 16'h0010 + 16'(i), 8'h10 + 8'(i));
    ioctl_download = 1'b0;
    seen_req = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); seen_req |= mem_req; end
    check("ovf_no_6th", {31'd0, seen_req}, 32'd0);
    check("ovf_done", {31'd0, load_done}, 32'd1);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // third download: clears overflow, region boundaries
    ioctl_download = 1'b1;
    tick();
    check("clr_ovf", {31'd0, overflow}, 32'd0);
    check("clr_done", {31'd0, load_done}, 32'd0);
    check("clr_hold", {31'd0, cpu_hold}, 32'd1);
    strobe(17'h0BFFF, 8'h01);
    strobe(17'h0CFFF, 8'h02);
    strobe(17'h1FFFF, 8'h03);
    ioctl_download = 1'b0;
    expect_write("b0", 2'd0, 16'hBFFF, 8'h01);
    expect_write("b1", 2'd1, 16'h0FFF, 8'h02);
    expect_write("b2", 2'd2, 16'h2FFF, 8'h03);
    tick(); tick();
    check("b_done", {31'd0, load_done}, 32'd1);
    strobe(17'h00020, 8'h99);
    seen_req = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); seen_req |= mem_req; end
    check("done_strobe_ignored", {31'd0, seen_req}, 32'd0);
    check("done_strobe_no_ovf", {31'd0, overflow}, 32'd0);

    // reset mid-write with three entries queued
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) strobe(17'h00030 + 17'(i), 8'h30 + 8'(i));
    check("mid_req", {31'd0, mem_req}, 32'd1);
    check("mid_data", {24'd0, mem_data}, 32'h30);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("mid_rst_data", {24'd0, mem_data}, 32'd0);
    check("mid_rst_done", {31'd0, load_done}, 32'd0);
    ioctl_download = 1'b0;
    mem_ack = 1'b1;
    #2 reset_n = 1'b1;
    tick();
    mem_ack = 1'b0;
    seen_req = mem_req;
    for (int i = 0; i < 6; i++) begin tick(); seen_req |= mem_req; end
    check("post_rst_no_write", {31'd0, seen_req}, 32'd0);
    check("post_rst_idle_hold", {31'd0, cpu_hold}, 32'd1);
    ioctl_download = 1'b1;
    tick();
    strobe(17'h0C0AA, 8'h5A);
    ioctl_download = 1'b0;
    expect_write("post_rst_w", 2'd1, 16'h00AA, 8'h5A);
    tick(); tick();
    check("post_rst_done", {31'd0, load_done}, 32'd1);

`ifdef ROM_LOADER_CHECKSUM_EN
    ioctl_download = 1'b1;
    tick();
    check("cs_clear", {24'd0, checksum}, 32'd0);
    strobe(17'h00000, 8'hFF);
    strobe(17'h00001, 8'h02);
    strobe(17'h00002, 8'h10);
    ioctl_download = 1'b0;
    expect_write("cs_w0", 2'd0, 16'h0000, 8'hFF);
    expect_write("cs_w1", 2'd0, 16'h0001, 8'h02);
    expect_write("cs_w2", 2'd0, 16'h0002, 8'h10);
    tick(); tick();
    check("cs_value", {24'd0, checksum}, 32'h11);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_loader_ctrl.md
ROM_LOADER_CTRL -- requirements
Module: rom_loader_ctrl

Interface
REQ-001 Parameter SND_BASE, default 17'h0C000, first byte of sound-CPU ROM region.
REQ-002 Parameter GFX_BASE, default 17'h0D000, first byte of graphics ROM region; region ends at 17'h1FFFF.
REQ-003 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ioctl_download  in  1  high while HPS download session is active.
REQ-006 ioctl_wr  in  1  one-cycle strobe, byte valid on ioctl_addr/ioctl_dout.
REQ-007 ioctl_addr  in  17  download byte address.
REQ-008 ioctl_dout  in  8  download byte.
REQ-009 mem_req  out  1  write request to ROM memories; held until acked.
REQ-010 mem_ack  in  1  one-cycle acknowledge from target memory.
REQ-011 mem_sel  out  2  target region: 0 main, 1 sound, 2 gfx.
REQ-012 mem_addr  out  16  region-relative byte address.
REQ-013 mem_data  out  8  byte to write.
REQ-014 cpu_hold  out  1  holds game CPUs in reset while high.
REQ-015 load_done  out  1  high once a complete load has drained.
REQ-016 overflow  out  1  sticky: a byte was dropped.

Function
REQ-017 States: IDLE, LOAD, DRAIN, DONE; IDLE is the state after reset.
REQ-018 IDLE -> LOAD when ioctl_download=1; LOAD -> DRAIN when ioctl_download falls; DRAIN -> DONE when FIFO empty and no mem_req outstanding; DONE -> LOAD when ioctl_download rises again.
REQ-019 Entering LOAD from IDLE or DONE clears load_done and overflow in that same cycle.
REQ-020 cpu_hold=1 in IDLE, LOAD, DRAIN; cpu_hold=0 only in DONE.
REQ-021 load_done=1 only in DONE.
REQ-022 Bytes are queued in a 4-entry FIFO of {addr,data}; a strobe while LOAD with FIFO not full is pushed the same cycle.
REQ-023 Strobe with FIFO full: byte dropped, overflow set, FIFO contents unchanged.
REQ-024 Strobes outside LOAD are ignored and do not set overflow.
REQ-025 Region decode: addr < SND_BASE -> sel 0, offset addr; SND_BASE <= addr < GFX_BASE -> sel 1, offset addr-SND_BASE; else sel 2, offset addr-GFX_BASE; offset truncated to 16 bits.
REQ-026 Output stage: when mem_req=0 and FIFO non-empty, pop head, register sel/addr/data, assert mem_req next cycle.
REQ-027 mem_sel, mem_addr, mem_data stable while mem_req=1; mem_req drops the cycle after mem_ack; next entry may issue the following cycle (max one write per 2 cycles).
REQ-028 mem_ack while mem_req=0 is ignored.
REQ-029 Simultaneous push and pop in one cycle: both occur, count unchanged; a push into a full FIFO popped in the same cycle is accepted.
REQ-030 FIFO pointers wrap modulo 4; count is 3 bits, 0..4.
REQ-031 ioctl_download rising in DRAIN: remain in DRAIN, drain, then DONE -> LOAD; strobes during this DRAIN are ignored.

Reset
REQ-032 Asserting reset_n=0 at any time, including mid-write, forces IDLE, empties FIFO, and drives mem_req=0, mem_sel=0, mem_addr=0, mem_data=0, cpu_hold=1, load_done=0, overflow=0 without waiting for a clock.
REQ-033 Outstanding mem_ack after reset release is ignored per REQ-028.

Configuration
REQ-034 Macro ROM_LOADER_CHECKSUM_EN: when defined, adds output checksum [7:0], an 8-bit wrapping sum of every byte issued on mem_data at its mem_ack, cleared on entry to LOAD and on reset, frozen in DONE.
REQ-035 Without ROM_LOADER_CHECKSUM_EN the checksum port and adder do not exist; all other behaviour is identical.

Verification
REQ-036 Download 3 bytes to addr 0x00000, 0x0C001, 0x0D002 with mem_ack 1 cycle after each mem_req -> writes (sel0,0x0000), (sel1,0x0001), (sel2,0x0002) in order; load_done=1, cpu_hold=0 after download falls.
REQ-037 Hold mem_ack=0, issue 6 strobes in LOAD -> first byte registered on the outputs, 4 queued, 6th dropped, overflow=1; release ack -> exactly 5 writes.
REQ-038 Strobe at addr 0x0BFFF and 0x0CFFF and 0x1FFFF -> sel/addr (0,0xBFFF), (1,0x0FFF), (2,0x2FFF).
REQ-039 Assert reset_n=0 while mem_req=1 with 3 entries queued -> mem_req=0, cpu_hold=1, FIFO empty immediately; no write after release.
REQ-040 Second download after DONE -> load_done and overflow clear on entry to LOAD, cpu_hold returns to 1.
REQ-041 With ROM_LOADER_CHECKSUM_EN, bytes 0xFF, 0x02, 0x10 -> checksum=0x11.
